tick_timer_arbiter: RTL and testbench

//   Shares one WIDTH-bit loadable down-counter (timeout/tick generator) among
//   N_REQ requesters. Arbitrates requests round-robin, loads the winner's delay,

---
 rtl/tick_timer_arbiter.sv | 92 +++++++++
 tb/tb_tick_timer_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tick_timer_arbiter.sv
// rtl/tick_timer_arbiter.sv - one loadable down-counter shared round-robin among N_REQ requesters
module tick_timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 25
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_delay,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_busy,
  output logic [WIDTH-1:0]       o_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    last, last_nxt;
  logic [IW-1:0]    owner, owner_nxt;
  logic [IW-1:0]    winner, cand;
  logic             found;
  logic [WIDTH-1:0] count_nxt;
  logic [N_REQ-1:0] gnt_nxt, done_nxt;

  // Round-robin search starts just past the last winner, so a requester that
  // keeps its request up is served only after everyone else pending.
  always_comb begin
    winner = last;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last) + i) % N_REQ);
      if (!found && i_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = o_count;
    owner_nxt = owner;
    last_nxt  = last;
    gnt_nxt   = '0;
    done_nxt  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          count_nxt       = i_delay[int'(winner)*WIDTH +: WIDTH];
          owner_nxt       = winner;
          last_nxt        = winner;
          gnt_nxt[winner] = 1'b1;
          state_nxt       = COUNT;
        end
      end
      COUNT: begin
        if (o_count != '0) begin
          count_nxt = o_count - 1'b1;
        end else begin
          done_nxt[owner] = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      o_count <= '0;
      owner   <= '0;
      last    <= IW'(N_REQ - 1);
      o_gnt   <= '0;
      o_done  <= '0;
    end else begin
      state   <= state_nxt;
      o_count <= count_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      o_gnt   <= gnt_nxt;
      o_done  <= done_nxt;
    end
  end

  assign o_busy = (state == COUNT);

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// tb/tb_tick_timer_arbiter.sv - directed vector bench for tick_timer_arbiter
module tb_tick_timer_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] delay;
  logic [N-1:0]   gnt, done;
  logic           busy;
  logic [W-1:0]   count;

  int pass_cnt = 0;
  int total_cnt = 0;

  tick_timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_delay(delay),
    .o_gnt(gnt), .o_done(done), .o_busy(busy), .o_count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rst;
    logic [N-1:0] req;
    logic [N*W-1:0] delay;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         busy;
    logic [W-1:0] count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [N-1:0] q, logic [N*W-1:0] d,
                              logic [N-1:0] g, logic [N-1:0] dn, logic b, logic [W-1:0] c);
    vec_t v;
    v.rst = r; v.req = q; v.delay = d; v.gnt = g; v.done = dn; v.busy = b; v.count = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Waits for the first nonzero o_gnt (is_done=0) or o_done (is_done=1) and
  // checks both its value and how many edges it took.
  task automatic expect_pulse(input string name, input bit is_done,
                              input logic [N-1:0] exp, input int exp_edges);
    int n;
    logic [N-1:0] s;
    n = 0;
    s = '0;
    while (s == '0 && n < exp_edges + 6) begin
      tick();
      n++;
      s = is_done ? done : gnt;
    end
    chk({name, "_value"}, 32'(s), 32'(exp));
    chk({name, "_edges"}, 32'(n), 32'(exp_edges));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit bad;
    rst = 1'b1; req = '0; delay = '0;
    #1;
    chk("reset_outputs", {gnt, done, busy, count}, '0);
    tick(); tick();
    rst = 1'b0;

    // Scenario 1: single request, delay 3
    vecs.push_back(mk(0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 4'd3));
    vecs.push_back(mk(0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 1, 4'd2));
    vecs.push_back(mk(0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 1, 4'd1));
    vecs.push_back(mk(0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 1, 4'd0));
    vecs.push_back(mk(0, 4'b0000, 16'h0003, 4'b0000, 4'b0001, 0, 4'd0));
    vecs.push_back(mk(0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 0, 4'd0));
    // Scenario 2: all four held, zero delays, round-robin from req 0
    vecs.push_back(mk(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'd0));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 4'b0001, 4'b0000, 1, 4'd0));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 4'b0000, 4'b0001, 0, 4'd0));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 4'b0010, 4'b0000, 1, 4'd0));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 4'b0000, 4'b0010, 0, 4'd0));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 4'b0100, 4'b0000, 1, 4'd0));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 4'b0000, 4'b0100, 0, 4'd0));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 4'b1000, 4'b0000, 1, 4'd0));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 4'b0000, 4'b1000, 0, 4'd0));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 4'b0001, 4'b0000, 1, 4'd0));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 4'b0000, 4'b0001, 0, 4'd0));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'd0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; delay = vecs[i].delay;
      tick();
      chk($sformatf("vec%0d", i), {gnt, done, busy, count},
          {vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].count});
    end
    rst = 1'b0; req = '0;

    // Scenario 3: requests raised during COUNT wait, then round-robin from owner
    do_reset();
    delay = {4'd2, 4'd5, 4'd1, 4'd0};
    req = 4'b0100;
    expect_pulse("s3_gnt2", 0, 4'b0100, 1);
    req = 4'b1010;
    expect_pulse("s3_done2", 1, 4'b0100, 6);
    expect_pulse("s3_gnt3", 0, 4'b1000, 1);
    req = 4'b0010;
    expect_pulse("s3_done3", 1, 4'b1000, 3);
    expect_pulse("s3_gnt1", 0, 4'b0010, 1);
    req = 4'b0000;
    expect_pulse("s3_done1", 1, 4'b0010, 2);

    // Scenario 4: full-scale delay counts down without wrap or early done
    do_reset();
    delay = {12'h000, 4'd15};
    req = 4'b0001;
    tick();
    chk("s4_gnt", {gnt, count}, {4'b0001, 4'd15});
    req = '0;
    bad = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (done != '0 || count != W'(15 - n) || !busy) bad = 1'b1;
    end
    chk("s4_no_early_done", 32'(bad), 32'd0);
    tick();
    chk("s4_done16", {done, busy, count}, {4'b0001, 1'b0, 4'd0});

    // Scenario 5: reset mid-count aborts without done; pointer back to req 0
    do_reset();
    delay = {4'd0, 4'd0, 4'd10, 4'd0};
    req = 4'b0010;
    tick();
    chk("s5_gnt1", gnt, 4'b0010);
    req = '0;
    tick(); tick(); tick();
    chk("s5_count7", count, 4'd7);
    rst = 1'b1;
    #1;
    chk("s5_async_clear", {gnt, done, busy, count}, '0);
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (done != '0 || busy) bad = 1'b1;
    end
    chk("s5_no_done", 32'(bad), 32'd0);
    req = 4'b1111;
    tick();
    chk("s5_prio0", gnt, 4'b0001);
    req = '0;
    tick();

    // Scenario 6: delay changed after grant is ignored
    do_reset();
    delay = {12'h000, 4'd5};
    req = 4'b0001;
    tick();
    chk("s6_gnt", {gnt, count}, {4'b0001, 4'd5});
    req = '0;
    tick(); tick();
    delay = {12'h000, 4'd1};
    expect_pulse("s6_done", 1, 4'b0001, 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
